fifo_write_arbiter: RTL and testbench

Round-robin arbiter that shares the single 32-bit write port of the SRAM FIFO between several first-word-fall-through data sources, such as the pixel RX, TLU and timestamp modules. It sits between those sources and the FIFO's pull-style input, where the FIFO asserts read-next and the arbiter presents valid data. It enforces a per-grant burst limit and throttles low-priority sources while the FIFO is near full. It also keeps a saturating count of words forwarded.

---
 rtl/fifo_write_arbiter.sv | 138 +++++++++++++
 tb/tb_fifo_write_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter feeding one 32-bit FIFO write port from N_SRC first-word-fall-through sources.
// Grants are burst-limited; FIFO_NEAR_FULL narrows eligibility to PRIO_MASK sources.
module fifo_write_arbiter #(
    parameter int          N_SRC         = 4,
    parameter int          MAX_BURST     = 16,
    parameter logic [31:0] CNT_RESET_VAL = 32'h0   // simulation hook: WORD_CNT value after reset
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST_N,
    input  logic [N_SRC-1:0]     SRC_VALID,
    input  logic [32*N_SRC-1:0]  SRC_DATA,
    output logic [N_SRC-1:0]     SRC_READ,
    input  logic [N_SRC-1:0]     EN_MASK,
    input  logic [N_SRC-1:0]     PRIO_MASK,
    output logic                 OUT_VALID,
    output logic [31:0]          OUT_DATA,
    input  logic                 OUT_READ,
    input  logic                 FIFO_FULL,
    input  logic                 FIFO_NEAR_FULL,
    output logic [N_SRC-1:0]     GRANT,
    output logic [31:0]          WORD_CNT,
    input  logic                 CNT_CLEAR
);

    localparam int IW = $clog2(N_SRC);

    typedef enum logic {ST_IDLE, ST_GRANT} state_t;

    state_t          r_state, w_state_next;
    logic [IW-1:0]   r_gnt_idx, w_gnt_idx_next;
    logic [IW-1:0]   r_last, w_last_next;
    logic [7:0]      r_burst_cnt, w_burst_cnt_next;
    logic            r_out_valid;
    logic [31:0]     r_out_data;
    logic [31:0]     r_word_cnt;

    logic [N_SRC-1:0] w_elig;
    logic             w_elig_g;
    logic             w_load;
    logic             w_pick_valid;
    logic [IW-1:0]    w_pick_idx;
    logic [31:0]      w_src_word [N_SRC];

    assign w_elig   = SRC_VALID & EN_MASK & ({N_SRC{~FIFO_NEAR_FULL}} | PRIO_MASK);
    assign w_elig_g = w_elig[r_gnt_idx];
    // Reset gating keeps sources from being popped while the block is held in reset.
    assign w_load   = BUS_RST_N & (r_state == ST_GRANT) & w_elig_g
                    & (~r_out_valid | OUT_READ) & ~FIFO_FULL;

    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
        assign w_src_word[gi] = SRC_DATA[32*gi +: 32];
        assign GRANT[gi]      = BUS_RST_N & (r_state == ST_GRANT) & (r_gnt_idx == IW'(gi));
        assign SRC_READ[gi]   = w_load & (r_gnt_idx == IW'(gi));
    end

    // Walk downward so the candidate closest after r_last is the one left standing.
    always_comb begin
        int cand;
        w_pick_valid = 1'b0;
        w_pick_idx   = r_last;
        cand         = 0;
        for (int k = N_SRC; k >= 1; k--) begin
            cand = (int'(r_last) + k) % N_SRC;
            if (w_elig[cand]) begin
                w_pick_valid = 1'b1;
                w_pick_idx   = IW'(cand);
            end
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_gnt_idx_next   = r_gnt_idx;
        w_last_next      = r_last;
        w_burst_cnt_next = r_burst_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_next     = ST_GRANT;
                    w_gnt_idx_next   = w_pick_idx;
                    w_last_next      = w_pick_idx;
                    w_burst_cnt_next = 8'd0;
                end
            end
            ST_GRANT: begin
                if (!w_elig_g) begin
                    w_state_next = ST_IDLE;
                end else if (w_load) begin
                    if (r_burst_cnt == 8'(MAX_BURST - 1)) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_burst_cnt_next = r_burst_cnt + 8'd1;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge BUS_CLK) begin
        if (!BUS_RST_N) begin
            r_state     <= ST_IDLE;
            r_gnt_idx   <= '0;
            r_last      <= IW'(N_SRC - 1);
            r_burst_cnt <= 8'd0;
        end else begin
            r_state     <= w_state_next;
            r_gnt_idx   <= w_gnt_idx_next;
            r_last      <= w_last_next;
            r_burst_cnt <= w_burst_cnt_next;
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (!BUS_RST_N) begin
            r_out_valid <= 1'b0;
            r_out_data  <= 32'h0;
            r_word_cnt  <= CNT_RESET_VAL;
        end else begin
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_src_word[r_gnt_idx];
            end else if (OUT_READ) begin
                r_out_valid <= 1'b0;
            end
            if (CNT_CLEAR) begin
                r_word_cnt <= 32'h0;
            end else if (w_load && (r_word_cnt != 32'hFFFF_FFFF)) begin
                r_word_cnt <= r_word_cnt + 32'd1;
            end
        end
    end

    assign OUT_VALID = r_out_valid;
    assign OUT_DATA  = r_out_data;
    assign WORD_CNT  = r_word_cnt;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: three instances share inputs (MAX_BURST 16, 2, and 2 with a
// near-saturated counter); every cycle each is compared against a behavioural model.
module tb_fifo_write_arbiter;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [N-1:0]    src_valid;
    logic [32*N-1:0] src_data;
    logic [N-1:0]    en_mask, prio_mask;
    logic            out_read, fifo_full, fifo_near_full, cnt_clear;

    logic [2:0][N-1:0] sread, grant;
    logic [2:0]        ov;
    logic [2:0][31:0]  od, wcnt;

    fifo_write_arbiter #(.N_SRC(N), .MAX_BURST(16)) dut_a (
        .BUS_CLK(clk), .BUS_RST_N(rst_n), .SRC_VALID(src_valid), .SRC_DATA(src_data),
        .SRC_READ(sread[0]), .EN_MASK(en_mask), .PRIO_MASK(prio_mask), .OUT_VALID(ov[0]),
        .OUT_DATA(od[0]), .OUT_READ(out_read), .FIFO_FULL(fifo_full),
        .FIFO_NEAR_FULL(fifo_near_full), .GRANT(grant[0]), .WORD_CNT(wcnt[0]),
        .CNT_CLEAR(cnt_clear));

    fifo_write_arbiter #(.N_SRC(N), .MAX_BURST(2)) dut_b (
        .BUS_CLK(clk), .BUS_RST_N(rst_n), .SRC_VALID(src_valid), .SRC_DATA(src_data),
        .SRC_READ(sread[1]), .EN_MASK(en_mask), .PRIO_MASK(prio_mask), .OUT_VALID(ov[1]),
        .OUT_DATA(od[1]), .OUT_READ(out_read), .FIFO_FULL(fifo_full),
        .FIFO_NEAR_FULL(fifo_near_full), .GRANT(grant[1]), .WORD_CNT(wcnt[1]),
        .CNT_CLEAR(cnt_clear));

    fifo_write_arbiter #(.N_SRC(N), .MAX_BURST(2), .CNT_RESET_VAL(32'hFFFF_FFFD)) dut_c (
        .BUS_CLK(clk), .BUS_RST_N(rst_n), .SRC_VALID(src_valid), .SRC_DATA(src_data),
        .SRC_READ(sread[2]), .EN_MASK(en_mask), .PRIO_MASK(prio_mask), .OUT_VALID(ov[2]),
        .OUT_DATA(od[2]), .OUT_READ(out_read), .FIFO_FULL(fifo_full),
        .FIFO_NEAR_FULL(fifo_near_full), .GRANT(grant[2]), .WORD_CNT(wcnt[2]),
        .CNT_CLEAR(cnt_clear));

    // ---------------- behavioural model ----------------
    typedef struct {
        int          g;      // granted source, -1 when idle
        int          last;
        int          burst;  // words already popped in this grant
        bit          ov;
        logic [31:0] od;
        logic [31:0] cnt;
    } mdl_t;

    mdl_t        m [3];
    int          mb [3]    = '{16, 2, 2};
    logic [31:0] cinit [3] = '{32'h0, 32'h0, 32'hFFFF_FFFD};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [N-1:0] elig_f();
        return src_valid & en_mask & ({N{~fifo_near_full}} | prio_mask);
    endfunction

    function automatic bit m_load(input int k);
        logic [N-1:0] el;
        el = elig_f();
        if (!rst_n || m[k].g < 0) return 1'b0;
        return el[m[k].g] && (!m[k].ov || out_read) && !fifo_full;
    endfunction

    task automatic m_reset(input int k);
        m[k].g = -1; m[k].last = N - 1; m[k].burst = 0;
        m[k].ov = 1'b0; m[k].od = 32'h0; m[k].cnt = cinit[k];
    endtask

    task automatic m_step(input int k);
        logic [N-1:0] el;
        bit ld;
        el = elig_f();
        ld = m_load(k);
        if (!rst_n) begin
            m_reset(k);
            return;
        end
        if (ld) begin
            m[k].od = src_data[32*m[k].g +: 32];
            m[k].ov = 1'b1;
        end else if (out_read) begin
            m[k].ov = 1'b0;
        end
        if (cnt_clear) m[k].cnt = 32'h0;
        else if (ld && m[k].cnt != 32'hFFFF_FFFF) m[k].cnt = m[k].cnt + 1;
        if (m[k].g < 0) begin
            for (int j = 1; j <= N; j++) begin
                int s;
                s = (m[k].last + j) % N;
                if (el[s]) begin
                    m[k].g = s; m[k].last = s; m[k].burst = 0;
                    break;
                end
            end
        end else if (!el[m[k].g]) begin
            m[k].g = -1;
        end else if (ld) begin
            if (m[k].burst + 1 == mb[k]) m[k].g = -1;
            else m[k].burst++;
        end
    endtask

    task automatic m_check(input int k);
        logic [N-1:0] eg, es;
        eg = (rst_n && m[k].g >= 0) ? N'(1 << m[k].g) : '0;
        es = m_load(k) ? N'(1 << m[k].g) : '0;
        chk($sformatf("dut%0d GRANT", k),     32'(grant[k]), 32'(eg));
        chk($sformatf("dut%0d SRC_READ", k),  32'(sread[k]), 32'(es));
        chk($sformatf("dut%0d OUT_VALID", k), 32'(ov[k]),    32'(m[k].ov));
        chk($sformatf("dut%0d OUT_DATA", k),  od[k],         m[k].od);
        chk($sformatf("dut%0d WORD_CNT", k),  wcnt[k],       m[k].cnt);
    endtask

    // ---------------- sources and sink ----------------
    logic [31:0] q [N][$];
    int          seq_in [N];
    int          next_seq [N];
    int          pushed, delivered;
    int          drv;     // instance whose SRC_READ pops the sources
    bit          use_q;
    logic [N-1:0] glog [$];
    logic [N-1:0] slog [$];

    task automatic push(input int s);
        q[s].push_back({8'(s), 24'(seq_in[s])});
        seq_in[s]++;
        pushed++;
    endtask

    task automatic refresh();
        if (use_q) begin
            for (int s = 0; s < N; s++) begin
                src_valid[s]       = (q[s].size() > 0);
                src_data[32*s +: 32] = (q[s].size() > 0) ? q[s][0] : 32'h0;
            end
        end
    endtask

    task automatic cycle();
        logic [31:0] w;
        int s;
        @(negedge clk);
        for (int k = 0; k < 3; k++) m_check(k);
        glog.push_back(grant[drv]);
        slog.push_back(sread[drv]);
        if (use_q && rst_n && ov[drv] && out_read) begin
            w = od[drv];
            s = int'(w[31:24]);
            if (s < N) begin
                chk($sformatf("order src%0d", s), 32'(w[23:0]), 32'(next_seq[s]));
                next_seq[s] = int'(w[23:0]) + 1;
            end else begin
                chk("source id", 32'(s), 32'(N - 1));
            end
            delivered++;
        end
        if (use_q) begin
            for (int i = 0; i < N; i++)
                if (sread[drv][i] && q[i].size() > 0) void'(q[i].pop_front());
        end
        for (int k = 0; k < 3; k++) m_step(k);
        @(posedge clk);
        #1;
        refresh();
    endtask

    task automatic do_reset(input int d, input logic [N-1:0] fill_mask, input int fill_n);
        drv = d; use_q = 1'b1;
        pushed = 0; delivered = 0;
        for (int s = 0; s < N; s++) begin
            q[s].delete(); seq_in[s] = 0; next_seq[s] = 0;
            if (fill_mask[s]) for (int i = 0; i < fill_n; i++) push(s);
        end
        fifo_full = 1'b0; fifo_near_full = 1'b0; out_read = 1'b1; cnt_clear = 1'b0;
        en_mask = '1; prio_mask = '0;
        rst_n = 1'b0;
        refresh();
        repeat (3) cycle();
        rst_n = 1'b1;
        glog.delete(); slog.delete();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit           rst_n;
        logic [N-1:0] valid, prio;
        bit           nf, full, oread;
        logic [N-1:0] e_grant, e_sread;
        bit           e_ov;
        logic [31:0]  e_od;
        logic [31:0]  e_cnt;
    } row_t;

    row_t tbl [18];

    initial begin
        logic [N-1:0] exp_v;
        logic [31:0]  hold;
        int           cnt;
        bit           done;

        tbl[0]  = '{0, 4'b1111, 4'b0100, 0, 0, 1, 4'b0000, 4'b0000, 0, 32'h0,         0};
        tbl[1]  = '{0, 4'b1111, 4'b0100, 0, 0, 1, 4'b0000, 4'b0000, 0, 32'h0,         0};
        tbl[2]  = '{0, 4'b1111, 4'b0100, 0, 0, 1, 4'b0000, 4'b0000, 0, 32'h0,         0};
        tbl[3]  = '{1, 4'b1111, 4'b0100, 0, 0, 1, 4'b0000, 4'b0000, 0, 32'h0,         0};
        tbl[4]  = '{1, 4'b1111, 4'b0100, 0, 0, 1, 4'b0001, 4'b0001, 0, 32'h0,         0};
        tbl[5]  = '{1, 4'b1111, 4'b0100, 0, 0, 1, 4'b0001, 4'b0001, 1, 32'hA000_0000, 1};
        tbl[6]  = '{1, 4'b1111, 4'b0100, 1, 0, 1, 4'b0001, 4'b0000, 1, 32'hA000_0000, 2};
        tbl[7]  = '{1, 4'b1111, 4'b0100, 1, 0, 1, 4'b0000, 4'b0000, 0, 32'h0,         2};
        tbl[8]  = '{1, 4'b1111, 4'b0100, 1, 0, 1, 4'b0100, 4'b0100, 0, 32'h0,         2};
        tbl[9]  = '{1, 4'b1111, 4'b0100, 0, 0, 1, 4'b0100, 4'b0100, 1, 32'hA000_0002, 3};
        tbl[10] = '{1, 4'b0001, 4'b0100, 0, 0, 1, 4'b0100, 4'b0000, 1, 32'hA000_0002, 4};
        tbl[11] = '{1, 4'b0001, 4'b0100, 0, 0, 1, 4'b0000, 4'b0000, 0, 32'h0,         4};
        tbl[12] = '{1, 4'b0001, 4'b0100, 0, 0, 1, 4'b0001, 4'b0001, 0, 32'h0,         4};
        tbl[13] = '{1, 4'b0001, 4'b0100, 0, 0, 1, 4'b0001, 4'b0001, 1, 32'hA000_0000, 5};
        tbl[14] = '{1, 4'b0001, 4'b0100, 0, 1, 0, 4'b0001, 4'b0000, 1, 32'hA000_0000, 6};
        tbl[15] = '{1, 4'b0001, 4'b0100, 0, 1, 0, 4'b0001, 4'b0000, 1, 32'hA000_0000, 6};
        tbl[16] = '{1, 4'b0001, 4'b0100, 0, 0, 1, 4'b0001, 4'b0001, 1, 32'hA000_0000, 6};
        tbl[17] = '{1, 4'b0000, 4'b0100, 0, 0, 1, 4'b0001, 4'b0000, 1, 32'hA000_0000, 7};

        drv = 0; use_q = 1'b0; pushed = 0; delivered = 0;
        src_data  = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
        en_mask   = '1; cnt_clear = 1'b0;
        for (int k = 0; k < 3; k++) m_reset(k);

        // Table: reset, near-full throttling to prio src2, resume of src0, full backpressure.
        for (int r = 0; r < 18; r++) begin
            rst_n = tbl[r].rst_n; src_valid = tbl[r].valid; prio_mask = tbl[r].prio;
            fifo_near_full = tbl[r].nf; fifo_full = tbl[r].full; out_read = tbl[r].oread;
            if (r == 0) begin
                @(posedge clk);
                #1;
            end
            @(negedge clk);
            chk($sformatf("tbl%0d GRANT", r),     32'(grant[0]), 32'(tbl[r].e_grant));
            chk($sformatf("tbl%0d SRC_READ", r),  32'(sread[0]), 32'(tbl[r].e_sread));
            chk($sformatf("tbl%0d OUT_VALID", r), 32'(ov[0]),    32'(tbl[r].e_ov));
            chk($sformatf("tbl%0d WORD_CNT", r),  wcnt[0],       tbl[r].e_cnt);
            if (tbl[r].e_ov) chk($sformatf("tbl%0d OUT_DATA", r), od[0], tbl[r].e_od);
            #0;
            for (int k = 0; k < 3; k++) m_check(k);
            for (int k = 0; k < 3; k++) m_step(k);
            @(posedge clk);
            #1;
        end

        // Round robin with MAX_BURST=2; instance c starts its counter at 0xFFFFFFFD.
        do_reset(1, 4'b1111, 20);
        repeat (12) cycle();
        chk("rr WORD_CNT after 12", wcnt[1], 32'd8);
        chk("sat WORD_CNT", wcnt[2], 32'hFFFF_FFFF);
        cycle();
        cnt_clear = 1'b1;
        cycle();
        cnt_clear = 1'b0;
        chk("clear+load WORD_CNT b", wcnt[1], 32'd0);
        chk("clear+load WORD_CNT c", wcnt[2], 32'd0);
        for (int t = 0; t < 14; t++) begin
            exp_v = (t % 3 == 0) ? 4'b0000 : 4'(1 << ((t / 3) % 4));
            chk($sformatf("rr grant t%0d", t), 32'(glog[t]), 32'(exp_v));
            chk($sformatf("rr read t%0d", t),  32'(slog[t]), 32'(exp_v));
        end

        // Burst limit: src1 alone, 40 words, MAX_BURST=16.
        do_reset(0, 4'b0010, 40);
        repeat (60) cycle();
        cnt = 0;
        for (int t = 0; t < 60; t++) begin
            bit e;
            e = (t > 0) && ((t - 1) % 17 != 16) && (cnt < 40);
            if (e) cnt++;
            chk($sformatf("burst read t%0d", t), 32'(slog[t][1]), 32'(e));
        end
        chk("burst WORD_CNT", wcnt[0], 32'd40);
        chk("burst delivered", 32'(delivered), 32'd40);

        // Full with no reads for 10 cycles while src3 holds the grant.
        do_reset(0, 4'b1000, 30);
        repeat (5) cycle();
        fifo_full = 1'b1; out_read = 1'b0;
        hold = od[0];
        for (int t = 0; t < 10; t++) begin
            cycle();
            chk("full OUT_DATA hold", od[0], hold);
            chk("full SRC_READ", 32'(sread[0]), 32'd0);
            chk("full GRANT", 32'(grant[0]), 32'b1000);
            chk("full OUT_VALID", 32'(ov[0]), 32'd1);
        end
        fifo_full = 1'b0; out_read = 1'b1;
        repeat (40) cycle();
        chk("full delivered", 32'(delivered), 32'd30);

        // Randomized traffic checked every cycle by the model, then drained.
        do_reset(0, 4'b0000, 0);
        for (int t = 0; t < 3000; t++) begin
            en_mask   = ($urandom_range(0, 9) == 0) ? N'($urandom) : '1;
            prio_mask = N'($urandom);
            if ($urandom_range(0, 19) == 0) fifo_near_full = ~fifo_near_full;
            fifo_full = ($urandom_range(0, 4) == 0);
            out_read  = ($urandom_range(0, 9) < 7);
            cnt_clear = ($urandom_range(0, 49) == 0);
            for (int s = 0; s < N; s++) if ($urandom_range(0, 7) == 0) push(s);
            refresh();
            cycle();
        end
        en_mask = '1; fifo_near_full = 1'b0; fifo_full = 1'b0; out_read = 1'b1; cnt_clear = 1'b0;
        refresh();
        done = 1'b0;
        for (int t = 0; t < 6000 && !done; t++) begin
            cycle();
            done = (q[0].size() == 0) && (q[1].size() == 0) && (q[2].size() == 0)
                && (q[3].size() == 0) && !ov[0];
        end
        chk("random drain finished", 32'(done), 32'd1);
        chk("random delivered", 32'(delivered), 32'(pushed));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
